// File: rtl/multi_cycle_controller.sv
`timescale 1ns/1ps
// multi_cycle_controller
// ----------------------
// Multi-cycle sequencer for an RV32I datapath with variable-latency memories.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The
// datapath control lines are decoded combinationally from the current state
// and the instruction-register fields.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   Op/funct3/funct7      fields of the instruction register
//   BrEq, BrLT            branch comparator results
//   IMemReady, DMemReady  memory completion strobes
//   IMemReq, DMemReq      memory requests
//   IRWrite, PCWrite      IR / PC load enables
//   PCSel                 0 = PC+4, 1 = target
//   RegWEn, MemRW         register-file write, 1 = store
//   ImmSel, ASel, BSel    immediate format and ALU operand selects
//   WBSel, ALUSel         write-back source and ALU operation
//   Fault                 sticky fault flag (set in TRAP)
//   State                 current FSM state, for debug
//
// Memory handshake: a request is raised on entry to FETCH/MEM and held
// until the matching ready is seen high in a cycle where the request is
// high; that cycle completes the access. A ready while its request is low is
// ignored. A request waiting TIMEOUT_CYCLES cycles without ready faults.
module multi_cycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       BrEq,
  input  logic       BrLT,
  input  logic       IMemReady,
  input  logic       DMemReady,
  output logic       IMemReq,
  output logic       DMemReq,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSel,
  output logic       RegWEn,
  output logic       MemRW,
  output logic [1:0] ImmSel,
  output logic       ASel,
  output logic       BSel,
  output logic [1:0] WBSel,
  output logic [3:0] ALUSel,
  output logic       Fault,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_TRAP   = 3'b111
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // The counter holds the number of ready-low cycles already spent; the
  // cycle in which it equals LIMIT_M1 is the last one ready may arrive in.
  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic is_r, is_i, is_lw, is_sw, is_b, is_jal, is_jalr, is_legal;
  logic taken;
  logic [3:0] alu_arith;

  // Only funct7[5] carries meaning for RV32I base ALU decode.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign is_r     = (Op == OP_R);
  assign is_i     = (Op == OP_I);
  assign is_lw    = (Op == OP_LW);
  assign is_sw    = (Op == OP_SW);
  assign is_b     = (Op == OP_B);
  assign is_jal   = (Op == OP_JAL);
  assign is_jalr  = (Op == OP_JALR);
  assign is_legal = is_r | is_i | is_lw | is_sw | is_b | is_jal | is_jalr;

  // funct3 010/011 are not branch encodings; they never take.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:          taken = BrEq;
      3'b001:          taken = ~BrEq;
      3'b100, 3'b110:  taken = BrLT;
      3'b101, 3'b111:  taken = ~BrLT;
      default:         taken = 1'b0;
    endcase
  end

  // Shared R / I-ALU decode. funct7[5] selects SUB only for R-type (ADDI
  // has no SUB form) and SRA/SRAI for both.
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000:  alu_arith = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_arith = ALU_SLL;
      3'b010:  alu_arith = ALU_SLT;
      3'b011:  alu_arith = ALU_SLTU;
      3'b100:  alu_arith = ALU_XOR;
      3'b101:  alu_arith = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = 8'd0;
      end
      S_FETCH: begin
        if (IMemReady)                state_d = S_DECODE;
        else if (cnt_q == LIMIT_M1)   state_d = S_TRAP;
        else                          cnt_d   = cnt_q + 8'd1;
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_b) begin
          state_d = S_FETCH;
          cnt_d   = 8'd0;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
          cnt_d   = 8'd0;
        end else if (is_r || is_i || is_jal || is_jalr) begin
          state_d = S_WB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        if (DMemReady) begin
          if (is_sw) begin
            state_d = S_FETCH;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == LIMIT_M1) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = 8'd0;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control outputs. Everything not driven for a state stays 0, which also
  // makes IDLE (and therefore reset) an all-zero output vector.
  always_comb begin
    IMemReq = 1'b0;
    DMemReq = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCSel   = 1'b0;
    RegWEn  = 1'b0;
    MemRW   = 1'b0;
    ImmSel  = 2'b00;
    ASel    = 1'b0;
    BSel    = 1'b0;
    WBSel   = 2'b00;
    ALUSel  = ALU_ADD;
    Fault   = 1'b0;
    case (state_q)
      S_FETCH: begin
        IMemReq = 1'b1;
        IRWrite = IMemReady;
      end
      S_DECODE: begin
        if (is_sw)       ImmSel = 2'b01;
        else if (is_b)   ImmSel = 2'b10;
        else if (is_jal) ImmSel = 2'b11;
        else             ImmSel = 2'b00;
      end
      S_EXEC: begin
        if (is_r) begin
          ALUSel = alu_arith;
        end else if (is_i) begin
          ALUSel = alu_arith;
          BSel   = 1'b1;
        end else if (is_lw || is_sw || is_jalr) begin
          BSel   = 1'b1;
        end else if (is_b) begin
          ASel    = 1'b1;
          BSel    = 1'b1;
          PCWrite = 1'b1;
          PCSel   = taken;
        end else if (is_jal) begin
          ASel   = 1'b1;
          BSel   = 1'b1;
        end
      end
      S_MEM: begin
        DMemReq = 1'b1;
        MemRW   = is_sw;
        PCWrite = is_sw & DMemReady;
      end
      S_WB: begin
        RegWEn  = 1'b1;
        PCWrite = 1'b1;
        if (is_lw) begin
          WBSel = 2'b00;
        end else if (is_jal || is_jalr) begin
          WBSel = 2'b10;
          PCSel = 1'b1;
        end else begin
          WBSel = 2'b01;
        end
      end
      S_TRAP:  Fault = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
`timescale 1ns/1ps
module tb_multi_cycle_controller;

  localparam int TMO = 255;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] ST_IDLE = 3'b000, ST_FETCH = 3'b001, ST_DECODE = 3'b010;
  localparam logic [2:0] ST_EXEC = 3'b011, ST_MEM = 3'b100, ST_WB = 3'b101, ST_TRAP = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       BrEq, BrLT, IMemReady, DMemReady;
  logic       IMemReq, DMemReq, IRWrite, PCWrite, PCSel, RegWEn, MemRW;
  logic [1:0] ImmSel, WBSel;
  logic       ASel, BSel, Fault;
  logic [3:0] ALUSel;
  logic [2:0] State;

  multi_cycle_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .BrEq(BrEq), .BrLT(BrLT), .IMemReady(IMemReady), .DMemReady(DMemReady),
    .IMemReq(IMemReq), .DMemReq(DMemReq), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSel(PCSel), .RegWEn(RegWEn), .MemRW(MemRW), .ImmSel(ImmSel),
    .ASel(ASel), .BSel(BSel), .WBSel(WBSel), .ALUSel(ALUSel),
    .Fault(Fault), .State(State)
  );

  typedef struct packed {
    logic       imreq, dmreq, irw, pcw, pcsel, regw, memrw;
    logic [1:0] imm;
    logic       asel, bsel;
    logic [1:0] wb;
    logic [3:0] alu;
    logic       fault;
    logic [2:0] st;
  } obs_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       breq, brlt, ir, dr;
  } stim_t;

  // ---------------- scoreboard ----------------
  stim_t       stim_q[$];
  logic [20:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          trapped;

  function automatic obs_t sample();
    obs_t o;
    o.imreq = IMemReq; o.dmreq = DMemReq; o.irw = IRWrite; o.pcw = PCWrite;
    o.pcsel = PCSel;   o.regw = RegWEn;   o.memrw = MemRW; o.imm = ImmSel;
    o.asel = ASel;     o.bsel = BSel;     o.wb = WBSel;    o.alu = ALUSel;
    o.fault = Fault;   o.st = State;
    return o;
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_B:    return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (op != OP_R && op != OP_I) return 4'b0000;
    case (f3)
      3'd0: return (op == OP_R && f7[5]) ? 4'b0001 : 4'b0000;
      3'd1: return 4'b0101;
      3'd2: return 4'b1000;
      3'd3: return 4'b1001;
      3'd4: return 4'b0100;
      3'd5: return f7[5] ? 4'b0111 : 4'b0110;
      3'd6: return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JAL, OP_JALR};
  endfunction

  function automatic stim_t rnd_stim(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    stim_t s;
    s.op = op; s.f3 = f3; s.f7 = f7;
    s.breq = 1'($urandom_range(0, 1)); s.brlt = 1'($urandom_range(0, 1));
    s.ir   = 1'($urandom_range(0, 1)); s.dr   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic push(input stim_t s, input obs_t e, input string tag);
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_idle();
    obs_t e;
    e = '0;
    push(rnd_stim(7'd0, 3'd0, 7'd0), e, "idle_after_reset");
  endtask

  task automatic push_trap(input logic [6:0] op, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.st = ST_TRAP; e.fault = 1'b1;
      push(rnd_stim(op, 3'd0, 7'd0), e, "trap");
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction. iwait/dwait are
  // the number of ready-low cycles before the ready strobe; a wait of TMO or
  // more never delivers ready and ends in TRAP.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int iwait, input int dwait,
                             input bit fix_br, input logic eq, input logic lt);
    obs_t  e;
    stim_t s;
    trapped = 1'b0;
    for (int c = 0; c < iwait && c < TMO; c++) begin
      s = rnd_stim(op, f3, f7); s.ir = 1'b0;
      e = '0; e.st = ST_FETCH; e.imreq = 1'b1;
      push(s, e, "fetch_wait");
    end
    if (iwait >= TMO) begin
      trapped = 1'b1; push_trap(op, 4); return;
    end
    s = rnd_stim(op, f3, f7); s.ir = 1'b1;
    e = '0; e.st = ST_FETCH; e.imreq = 1'b1; e.irw = 1'b1;
    push(s, e, "fetch_done");

    s = rnd_stim(op, f3, f7);
    e = '0; e.st = ST_DECODE; e.imm = imm_of(op);
    push(s, e, "decode");
    if (!legal(op)) begin
      trapped = 1'b1; push_trap(op, 4); return;
    end

    s = rnd_stim(op, f3, f7);
    if (fix_br) begin s.breq = eq; s.brlt = lt; end
    e = '0; e.st = ST_EXEC; e.alu = alu_of(op, f3, f7);
    e.asel = (op == OP_B || op == OP_JAL);
    e.bsel = (op != OP_R);
    if (op == OP_B) begin
      e.pcw = 1'b1; e.pcsel = br_taken(f3, s.breq, s.brlt);
      push(s, e, "exec_branch");
      return;
    end
    push(s, e, "exec");

    if (op == OP_LW || op == OP_SW) begin
      for (int c = 0; c < dwait && c < TMO; c++) begin
        s = rnd_stim(op, f3, f7); s.dr = 1'b0;
        e = '0; e.st = ST_MEM; e.dmreq = 1'b1; e.memrw = (op == OP_SW);
        push(s, e, "mem_wait");
      end
      if (dwait >= TMO) begin
        trapped = 1'b1; push_trap(op, 4); return;
      end
      s = rnd_stim(op, f3, f7); s.dr = 1'b1;
      e = '0; e.st = ST_MEM; e.dmreq = 1'b1; e.memrw = (op == OP_SW);
      e.pcw = (op == OP_SW);
      push(s, e, "mem_done");
      if (op == OP_SW) return;
    end

    s = rnd_stim(op, f3, f7);
    e = '0; e.st = ST_WB; e.regw = 1'b1; e.pcw = 1'b1;
    if (op == OP_LW)                         e.wb = 2'b00;
    else if (op == OP_JAL || op == OP_JALR)  begin e.wb = 2'b10; e.pcsel = 1'b1; end
    else                                     e.wb = 2'b01;
    push(s, e, "wb");
  endtask

  // ---------------- driver ----------------
  task automatic run_steps(input int n);
    stim_t s;
    logic [20:0] e;
    string t;
    for (int i = 0; i < n && stim_q.size() > 0; i++) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); t = tag_q.pop_front();
      @(negedge clk);
      Op = s.op; funct3 = s.f3; funct7 = s.f7;
      BrEq = s.breq; BrLT = s.brlt; IMemReady = s.ir; DMemReady = s.dr;
      #1;
      check(t, sample(), e);
    end
  endtask

  task automatic run_all();
    run_steps(stim_q.size());
  endtask

  // Asserted mid-cycle so the check shows the asynchronous effect; released
  // just after a rising edge so the following edge is the first one out of reset.
  task automatic apply_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    #1 check("async_reset", sample(), '0);
    repeat (2) @(negedge clk);
    #1 check("reset_hold", sample(), '0);
    stim_q.delete(); exp_q.delete(); tag_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    push_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] ops[7];
    logic [6:0] op, f7;
    logic [2:0] f3;
    int iw, dw;
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JAL, OP_JALR};

    rst = 1'b0; Op = '0; funct3 = '0; funct7 = '0;
    BrEq = 1'b0; BrLT = 1'b0; IMemReady = 1'b1; DMemReady = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("power_on_reset", sample(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    push_idle();

    // Directed instructions.
    model_instr(OP_R,    3'b000, 7'h00, 0, 0, 0, 0, 0);   // ADD
    model_instr(OP_LW,   3'b010, 7'h00, 0, 3, 0, 0, 0);   // LW, 3 wait cycles
    model_instr(OP_B,    3'b001, 7'h00, 0, 0, 1, 0, 0);   // BNE, BrEq=0: taken
    model_instr(OP_B,    3'b000, 7'h00, 0, 0, 1, 0, 0);   // BEQ, BrEq=0: not taken
    model_instr(OP_JALR, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    model_instr(OP_JAL,  3'b000, 7'h00, 1, 0, 0, 0, 0);
    model_instr(OP_SW,   3'b010, 7'h00, 2, 2, 0, 0, 0);
    model_instr(OP_R,    3'b000, 7'h20, 0, 0, 0, 0, 0);   // SUB
    model_instr(OP_R,    3'b101, 7'h20, 0, 0, 0, 0, 0);   // SRA
    model_instr(OP_I,    3'b000, 7'h20, 0, 0, 0, 0, 0);   // ADDI with imm bit 10 set
    model_instr(OP_I,    3'b101, 7'h20, 0, 0, 0, 0, 0);   // SRAI
    model_instr(OP_B,    3'b010, 7'h00, 0, 0, 1, 1, 1);   // non-branch funct3
    run_all();

    // Ready arrives in the last allowed cycle of the fetch wait.
    model_instr(OP_R, 3'b100, 7'h00, TMO - 1, 0, 0, 0, 0);
    run_all();

    // Randomized legal instruction stream.
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom_range(0, 127));
      iw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3);
      model_instr(op, f3, f7, iw, dw, 0, 0, 0);
      run_all();
    end

    // Reset while a load waits in MEM with DMemReq high.
    model_instr(OP_LW, 3'b010, 7'h00, 0, 6, 0, 0, 0);
    run_steps(5);
    apply_reset();
    model_instr(OP_R, 3'b111, 7'h00, 0, 0, 0, 0, 0);
    run_all();

    // Illegal opcode.
    model_instr(7'b1111111, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    run_all();
    check("illegal_trapped", {20'd0, trapped}, 21'd1);
    apply_reset();

    // Fetch timeout.
    model_instr(OP_R, 3'b000, 7'h00, TMO, 0, 0, 0, 0);
    run_all();
    apply_reset();

    // Data-memory timeout on a store.
    model_instr(OP_SW, 3'b010, 7'h00, 0, TMO, 0, 0, 0);
    run_all();
    apply_reset();
    model_instr(OP_JAL, 3'b000, 7'h00, 0, 0, 0, 0, 0);
    run_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
